// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared sizing constants and Gray-code helper used by both
//               pointer domains of the asynchronous FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int PTR_W  = ADDR_W + 1;

  // Binary to reflected Gray code; callers cast the result to their width.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ptr_sync.sv
`default_nettype none
// ============================================================================
// Module      : ptr_sync
// Description : Two-flop synchronizer for a Gray-coded pointer crossing into
//               the local clock domain.
// Revision    : 1.0 - initial release
// ============================================================================
module ptr_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q1;
  logic [WIDTH-1:0] r_q2;

  // Two back-to-back flops; only r_q2 is safe to consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q1 <= '0;
      r_q2 <= '0;
    end else begin
      r_q1 <= i_d;
      r_q2 <= r_q1;
    end
  end

  assign o_q = r_q2;

endmodule
`default_nettype wire

// File: rtl/fifo_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_reader
// Description : Read side of an asynchronous FIFO: synchronizes the write
//               pointer, maintains the binary/Gray read pointer and registered
//               empty flag, and presents entries through a valid/ready
//               output register.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_reader #(
  parameter int DATA_W = fifo_pkg::DATA_W,
  parameter int ADDR_W = fifo_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W:0]   wptr_gray,
  input  logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] r_addr,
  output logic [ADDR_W:0]   rptr_gray,
  output logic              empty,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready
);

  localparam int PTR_W = ADDR_W + 1;

  import fifo_pkg::*;

  logic [PTR_W-1:0]  w_wq2;
  logic [PTR_W-1:0]  r_rbin;
  logic [PTR_W-1:0]  r_rgray;
  logic              r_empty;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              w_load;
  logic [PTR_W-1:0]  w_rbin_next;
  logic [PTR_W-1:0]  w_rgray_next;

  // The write pointer is only ever observed through this synchronizer.
  ptr_sync #(
    .WIDTH (PTR_W)
  ) u_wptr_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (wptr_gray),
    .o_q   (w_wq2)
  );

  // Fetch a new entry whenever one exists and the output register is free
  // or being drained this cycle.
  always_comb begin
    w_load       = !r_empty && (!r_rd_valid || rd_ready);
    w_rbin_next  = r_rbin + {{(PTR_W-1){1'b0}}, w_load};
    w_rgray_next = PTR_W'(bin2gray(32'(w_rbin_next)));
  end

  // Read pointer, registered Gray pointer, empty flag and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rbin     <= '0;
      r_rgray    <= '0;
      r_empty    <= 1'b1;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rbin  <= w_rbin_next;
      r_rgray <= w_rgray_next;
      // Full-width compare: pointers differing only in the MSB mean full.
      r_empty <= (w_rgray_next == w_wq2);
      if (w_load) begin
        r_rd_data  <= mem_data;
        r_rd_valid <= 1'b1;
      end else if (rd_ready) begin
        r_rd_valid <= 1'b0;
      end
    end
  end

  assign r_addr    = r_rbin[ADDR_W-1:0];
  assign rptr_gray = r_rgray;
  assign empty     = r_empty;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_reader
// Description : Directed self-checking bench for fifo_reader with a simple
//               behavioural write side and memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] wptr_gray = 4'b0000;
  logic [7:0] mem_data;
  logic [2:0] r_addr;
  logic [3:0] rptr_gray;
  logic       empty;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready = 1'b0;

  logic [7:0] mem [0:7];
  logic [3:0] wbin = 4'd0;
  logic [7:0] got [0:15];
  int         got_n;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  assign mem_data = mem[r_addr];

  fifo_reader #(
    .DATA_W (8),
    .ADDR_W (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wptr_gray (wptr_gray),
    .mem_data  (mem_data),
    .r_addr    (r_addr),
    .rptr_gray (rptr_gray),
    .empty     (empty),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready)
  );

  // Write side model: store entry, advance binary pointer, publish Gray.
  task automatic write_entry(input logic [7:0] d);
    mem[wbin[2:0]] = d;
    wbin           = wbin + 4'd1;
    wptr_gray      = wbin ^ (wbin >> 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    wptr_gray = 4'b0000;
    wbin      = 4'd0;
    rd_ready  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Record accepted data; sampled at negedge, ahead of the accepting edge.
  task automatic collect(input int n, input int budget);
    got_n = 0;
    for (int c = 0; c < budget && got_n < n; c++) begin
      if (rd_valid && rd_ready) begin
        got[got_n] = rd_data;
        got_n++;
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    checks++; if (empty !== 1'b1)      begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (rd_valid !== 1'b0)   begin errors++; $display("FAIL reset_valid got %b exp 0", rd_valid); end
    checks++; if (r_addr !== 3'b000)   begin errors++; $display("FAIL reset_raddr got %b exp 000", r_addr); end
    checks++; if (rptr_gray !== 4'b0)  begin errors++; $display("FAIL reset_rptr got %b exp 0000", rptr_gray); end
    checks++; if (rd_data !== 8'h00)   begin errors++; $display("FAIL reset_data got %h exp 00", rd_data); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (empty !== 1'b1 || rd_valid !== 1'b0)
      begin errors++; $display("FAIL release_edge empty %b valid %b exp 1 0", empty, rd_valid); end
  endtask

  task automatic test_single();
    do_reset();
    rd_ready = 1'b1;
    write_entry(8'h55);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_n1 got %b exp 1", empty); end
    @(posedge clk); #1;
    checks++; if (empty !== 1'b0 || rd_valid !== 1'b0)
      begin errors++; $display("FAIL single_n2 empty %b valid %b exp 0 0", empty, rd_valid); end
    @(posedge clk); #1;
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h55)
      begin errors++; $display("FAIL single_n3 valid %b data %h exp 1 55", rd_valid, rd_data); end
    checks++; if (empty !== 1'b1 || rptr_gray !== 4'b0001)
      begin errors++; $display("FAIL single_n3_ptr empty %b rptr %b exp 1 0001", empty, rptr_gray); end
    @(posedge clk); #1;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL single_n4_valid got %b exp 0", rd_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    write_entry(8'hFF);
    @(negedge clk);
    write_entry(8'hF0);
    repeat (6) @(posedge clk); #1;
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'hFF || r_addr !== 3'b001 || empty !== 1'b0)
      begin errors++; $display("FAIL bp_hold valid %b data %h addr %b empty %b exp 1 ff 001 0", rd_valid, rd_data, r_addr, empty); end
    repeat (2) @(posedge clk); #1;
    checks++; if (rd_data !== 8'hFF || r_addr !== 3'b001)
      begin errors++; $display("FAIL bp_hold2 data %h addr %b exp ff 001", rd_data, r_addr); end
    @(negedge clk);
    rd_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'hF0 || r_addr !== 3'b010 || empty !== 1'b1)
      begin errors++; $display("FAIL bp_next valid %b data %h addr %b empty %b exp 1 f0 010 1", rd_valid, rd_data, r_addr, empty); end
    @(posedge clk); #1;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL bp_drain valid %b exp 0", rd_valid); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      write_entry(8'h10 + 8'(i));
      @(negedge clk);
    end
    repeat (6) @(posedge clk); #1;
    // rbin=1, wbin=9: pointers differ only in the MSB
    checks++; if (empty !== 1'b0 || rd_valid !== 1'b1 || rd_data !== 8'h10 || r_addr !== 3'b001 || rptr_gray !== 4'b0001)
      begin errors++; $display("FAIL full_msb empty %b valid %b data %h addr %b rptr %b exp 0 1 10 001 0001", empty, rd_valid, rd_data, r_addr, rptr_gray); end
    @(negedge clk);
    rd_ready = 1'b1;
    collect(9, 14);
    checks++; if (got_n !== 9) begin errors++; $display("FAIL wrap_drain1_count got %0d exp 9", got_n); end
    for (int i = 0; i < got_n; i++) begin
      checks++; if (got[i] !== 8'h10 + 8'(i))
        begin errors++; $display("FAIL wrap_drain1_data[%0d] got %h exp %h", i, got[i], 8'h10 + 8'(i)); end
    end
    checks++; if (empty !== 1'b1 || rptr_gray !== 4'b1101 || r_addr !== 3'b001)
      begin errors++; $display("FAIL wrap_mid empty %b rptr %b addr %b exp 1 1101 001", empty, rptr_gray, r_addr); end
    rd_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      write_entry(8'h20 + 8'(i));
      @(negedge clk);
    end
    repeat (6) @(posedge clk); #1;
    checks++; if (empty !== 1'b0 || rd_data !== 8'h20)
      begin errors++; $display("FAIL wrap_fill2 empty %b data %h exp 0 20", empty, rd_data); end
    @(negedge clk);
    rd_ready = 1'b1;
    collect(7, 12);
    checks++; if (got_n !== 7) begin errors++; $display("FAIL wrap_drain2_count got %0d exp 7", got_n); end
    for (int i = 0; i < got_n; i++) begin
      checks++; if (got[i] !== 8'h20 + 8'(i))
        begin errors++; $display("FAIL wrap_drain2_data[%0d] got %h exp %h", i, got[i], 8'h20 + 8'(i)); end
    end
    checks++; if (rptr_gray !== 4'b0000 || r_addr !== 3'b000 || empty !== 1'b1)
      begin errors++; $display("FAIL wrap_end rptr %b addr %b empty %b exp 0000 000 1", rptr_gray, r_addr, empty); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      write_entry(8'hA0 + 8'(i));
      @(negedge clk);
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    rd_ready = 1'b1;
    // A budget equal to the count demands one accepted entry per cycle.
    collect(8, 8);
    checks++; if (got_n !== 8) begin errors++; $display("FAIL stream_count got %0d exp 8", got_n); end
    for (int i = 0; i < got_n; i++) begin
      checks++; if (got[i] !== 8'hA0 + 8'(i))
        begin errors++; $display("FAIL stream_data[%0d] got %h exp %h", i, got[i], 8'hA0 + 8'(i)); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      write_entry(8'h30 + 8'(i));
      @(negedge clk);
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    rd_ready = 1'b1;
    collect(3, 3);
    checks++; if (got_n !== 3 || got[2] !== 8'h32)
      begin errors++; $display("FAIL rmid_pre count %0d last %h exp 3 32", got_n, got[2]); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rd_valid !== 1'b0 || empty !== 1'b1 || r_addr !== 3'b000 || rd_data !== 8'h00)
      begin errors++; $display("FAIL rmid_async valid %b empty %b addr %b data %h exp 0 1 000 00", rd_valid, empty, r_addr, rd_data); end
    wptr_gray = 4'b0000;
    wbin      = 4'd0;
    rd_ready  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    write_entry(8'hC3);
    repeat (5) @(posedge clk); #1;
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'hC3 || rptr_gray !== 4'b0001)
      begin errors++; $display("FAIL rmid_after valid %b data %h rptr %b exp 1 c3 0001", rd_valid, rd_data, rptr_gray); end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    test_reset();
    test_single();
    test_backpressure();
    test_full_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
